// File: rtl/sram_roi_reader_pkg.sv
// rtl/sram_roi_reader_pkg.sv - shared image constants, FSM states and pixel tags
//
// Purpose: frame geometry, state encoding and the {sof,eol,eof} pixel tag
//          shared by the ROI reader and its skid FIFO.
// Ports:   none (package).
package img_pkg;

  localparam int IMG_W  = 180;
  localparam int IMG_H  = 150;
  localparam int ADDR_W = 17;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_READ,
    ST_DRAIN
  } state_t;

  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } pix_tag_t;

  // 9-bit sums so that e.g. x0=200,w=100 cannot wrap back inside the frame.
  function automatic logic roi_reject(input logic [7:0] x0, input logic [7:0] y0,
                                      input logic [7:0] w, input logic [7:0] h,
                                      input int img_w, input int img_h);
    logic [8:0] x_end;
    logic [8:0] y_end;
    x_end = {1'b0, x0} + {1'b0, w};
    y_end = {1'b0, y0} + {1'b0, h};
    return (w == 8'd0) || (h == 8'd0) || (x_end > 9'(img_w)) || (y_end > 9'(img_h));
  endfunction

endpackage

// File: rtl/sram_roi_reader_if.sv
// rtl/sram_roi_reader_if.sv - pixel output stream interface
//
// Purpose: valid/ready pixel stream with frame and line markers.
// Ports:   pix_data/pix_valid/pix_sof/pix_eol/pix_eof driven by the master,
//          pix_ready driven by the slave.
interface sram_roi_reader_if #(
  parameter int DATA_W = 8
) ();

  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;
  logic              pix_ready;
  logic              pix_sof;
  logic              pix_eol;
  logic              pix_eof;

  modport master (
    output pix_data, pix_valid, pix_sof, pix_eol, pix_eof,
    input  pix_ready
  );

  modport slave (
    input  pix_data, pix_valid, pix_sof, pix_eol, pix_eof,
    output pix_ready
  );

endinterface

// File: rtl/sram_roi_reader_fifo.sv
// rtl/sram_roi_reader_fifo.sv - synchronous skid FIFO for returning RAM pixels
//
// Purpose: holds pixels plus tags that came back from the RAM until accepted.
// Ports:   clk, rst_n (async active-low), push/push_data, pop, head (oldest
//          entry), count (occupancy), empty.
module pix_skid_fifo #(
  parameter int FIFO_DEPTH = 3,
  parameter int WIDTH      = 11,
  parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_q;
  logic [PTR_W-1:0] rd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_pop;

  assign do_pop = pop && (cnt_q != '0);
  assign head   = mem_q[rd_q];
  assign count  = cnt_q;
  assign empty  = (cnt_q == '0);

  // Storage is not reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        wr_q <= (wr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_q <= (rd_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_q + PTR_W'(1);
      end
      case ({push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sram_roi_reader.sv
// rtl/sram_roi_reader.sv - streams a rectangular ROI out of the pixel RAM
//
// Purpose: on start, validates the ROI, then reads it row-major through one
//          RAM port and emits it as a valid/ready pixel stream.
// Ports:   clk, rst_n (async active-low); start + roi_x0/y0/w/h request;
//          addr_a/w_en_a/data_in_a/data_out_a RAM port (read only);
//          pix stream interface (master); busy, done and err status.
module sram_roi_reader #(
  parameter int IMG_W      = img_pkg::IMG_W,
  parameter int IMG_H      = img_pkg::IMG_H,
  parameter int ADDR_W     = img_pkg::ADDR_W,
  parameter int DATA_W     = img_pkg::DATA_W,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = RD_LAT + 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        roi_x0,
  input  logic [7:0]        roi_y0,
  input  logic [7:0]        roi_w,
  input  logic [7:0]        roi_h,
  output logic [ADDR_W-1:0] addr_a,
  output logic              w_en_a,
  output logic [DATA_W-1:0] data_in_a,
  input  logic [DATA_W-1:0] data_out_a,
  sram_roi_reader_if.master pix,
  output logic              busy,
  output logic              done,
  output logic              err
);

  import img_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int FW    = DATA_W + 3;

  state_t            state_q;
  logic [7:0]        x0_q, y0_q, w_q, h_q;
  logic [7:0]        col_q, row_q;
  logic [ADDR_W-1:0] addr_q, row_base_q;
  logic              busy_q, done_q, err_q;

  // Tag pipeline runs alongside the RAM read pipeline so each returning
  // word arrives together with its markers.
  logic [RD_LAT-1:0] sr_vld_q;
  pix_tag_t          sr_tag_q [RD_LAT];
  logic [CNT_W-1:0]  inflight_q;

  logic [CNT_W-1:0]  fifo_count;
  logic [FW-1:0]     fifo_head;
  logic              fifo_empty, fifo_push, fifo_pop, pix_vld;
  pix_tag_t          head_tag;

  logic              last_col, last_row, credit_ok, issue;
  logic [CNT_W:0]    occupancy;
  pix_tag_t          issue_tag;

  assign last_col  = (col_q == w_q - 8'd1);
  assign last_row  = (row_q == h_q - 8'd1);
  // Counting inflight reads as occupied space means a returning word always
  // finds a free FIFO slot.
  assign occupancy = {1'b0, fifo_count} + {1'b0, inflight_q};
  assign credit_ok = (occupancy < (CNT_W + 1)'(FIFO_DEPTH));
  assign issue     = (state_q == ST_READ) && credit_ok;

  always_comb begin
    issue_tag     = '0;
    issue_tag.sof = (row_q == 8'd0) && (col_q == 8'd0);
    issue_tag.eol = last_col;
    issue_tag.eof = last_col && last_row;
  end

  assign fifo_push = sr_vld_q[RD_LAT-1];
  assign pix_vld   = ~fifo_empty;
  assign fifo_pop  = pix_vld && pix.pix_ready;
  assign head_tag  = pix_tag_t'(fifo_head[2:0]);

  pix_skid_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (FW),
    .CNT_W      (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data ({data_out_a, sr_tag_q[RD_LAT-1]}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_vld_q   <= '0;
      inflight_q <= '0;
      for (int i = 0; i < RD_LAT; i++) sr_tag_q[i] <= '0;
    end else begin
      sr_vld_q[0] <= issue;
      sr_tag_q[0] <= issue_tag;
      for (int i = 1; i < RD_LAT; i++) begin
        sr_vld_q[i] <= sr_vld_q[i-1];
        sr_tag_q[i] <= sr_tag_q[i-1];
      end
      inflight_q <= inflight_q + CNT_W'(issue) - CNT_W'(fifo_push);
    end
  end

  // addr_q always holds the next address to issue, so the RAM sees it in the
  // first READ cycle without an extra register stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      x0_q       <= '0;
      y0_q       <= '0;
      w_q        <= '0;
      h_q        <= '0;
      col_q      <= '0;
      row_q      <= '0;
      addr_q     <= '0;
      row_base_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            x0_q    <= roi_x0;
            y0_q    <= roi_y0;
            w_q     <= roi_w;
            h_q     <= roi_h;
            // Rejection is decided on the request itself so err lands in
            // the CHECK cycle, one cycle after start.
            err_q   <= roi_reject(roi_x0, roi_y0, roi_w, roi_h, IMG_W, IMG_H);
            state_q <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          err_q <= 1'b0;
          if (err_q) begin
            state_q <= ST_IDLE;
          end else begin
            row_base_q <= ADDR_W'(y0_q * IMG_W);
            addr_q     <= ADDR_W'(y0_q * IMG_W) + ADDR_W'(x0_q);
            col_q      <= '0;
            row_q      <= '0;
            busy_q     <= 1'b1;
            state_q    <= ST_READ;
          end
        end
        ST_READ: begin
          if (issue) begin
            if (last_col) begin
              if (last_row) begin
                state_q <= ST_DRAIN;
              end else begin
                col_q      <= '0;
                row_q      <= row_q + 8'd1;
                row_base_q <= row_base_q + ADDR_W'(IMG_W);
                addr_q     <= row_base_q + ADDR_W'(IMG_W) + ADDR_W'(x0_q);
              end
            end else begin
              col_q  <= col_q + 8'd1;
              addr_q <= addr_q + ADDR_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if ((inflight_q == '0) && fifo_pop && head_tag.eof) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign addr_a        = addr_q;
  assign w_en_a        = 1'b0;
  assign data_in_a     = '0;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;

  // Head of an empty FIFO is stale storage; force the stream to zero then.
  assign pix.pix_valid = pix_vld;
  assign pix.pix_data  = pix_vld ? fifo_head[FW-1:3] : '0;
  assign pix.pix_sof   = pix_vld & head_tag.sof;
  assign pix.pix_eol   = pix_vld & head_tag.eol;
  assign pix.pix_eof   = pix_vld & head_tag.eof;

endmodule

// File: tb/tb_sram_roi_reader.sv
// tb/tb_sram_roi_reader.sv - scoreboard bench for sram_roi_reader at RD_LAT 1 and 3
module tb_sram_roi_reader;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, ready;
  logic [7:0]  roi_x0, roi_y0, roi_w, roi_h;
  logic [16:0] addr_a, addr_b;
  logic        wen_a, wen_b;
  logic [7:0]  din_a, din_b, dout_a, dout_b;
  logic        busy_a, busy_b, done_a, done_b, err_a, err_b;

  sram_roi_reader_if #(.DATA_W(8)) pix_a ();
  sram_roi_reader_if #(.DATA_W(8)) pix_b ();
  assign pix_a.pix_ready = ready;
  assign pix_b.pix_ready = ready;

  sram_roi_reader #(.RD_LAT(LAT_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start),
    .roi_x0(roi_x0), .roi_y0(roi_y0), .roi_w(roi_w), .roi_h(roi_h),
    .addr_a(addr_a), .w_en_a(wen_a), .data_in_a(din_a), .data_out_a(dout_a),
    .pix(pix_a), .busy(busy_a), .done(done_a), .err(err_a)
  );

  sram_roi_reader #(.RD_LAT(LAT_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start),
    .roi_x0(roi_x0), .roi_y0(roi_y0), .roi_w(roi_w), .roi_h(roi_h),
    .addr_a(addr_b), .w_en_a(wen_b), .data_in_a(din_b), .data_out_a(dout_b),
    .pix(pix_b), .busy(busy_b), .done(done_b), .err(err_b)
  );

  // RAM models: RAM[a] = a[7:0], read data valid RD_LAT edges after the address.
  logic [7:0] ram_a_q [LAT_A];
  logic [7:0] ram_b_q [LAT_B];
  always @(posedge clk) begin
    ram_a_q[0] <= addr_a[7:0];
    for (int i = 1; i < LAT_A; i++) ram_a_q[i] <= ram_a_q[i-1];
    ram_b_q[0] <= addr_b[7:0];
    for (int i = 1; i < LAT_B; i++) ram_b_q[i] <= ram_b_q[i-1];
  end
  assign dout_a = ram_a_q[LAT_A-1];
  assign dout_b = ram_b_q[LAT_B-1];

  int n_tests = 0;
  int n_fail  = 0;

  logic [10:0] exp_a[$];
  logic [10:0] exp_b[$];
  int acc_a = 0, acc_b = 0;
  int done_cnt_a = 0, done_cnt_b = 0, err_cnt_a = 0, err_cnt_b = 0;
  int max_a = 0, max_b = 0;
  logic wen_seen = 1'b0;
  logic stall_a = 1'b0, stall_b = 1'b0;
  logic [11:0] held_a, held_b;
  logic toggle_mode = 1'b0;
  int phase = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitors: sample half a cycle away from the active edge.
  always @(negedge clk) begin
    logic [31:0] e;
    if (wen_a === 1'b1 || wen_b === 1'b1) wen_seen = 1'b1;
    if (int'(dut_a.fifo_count) > max_a) max_a = int'(dut_a.fifo_count);
    if (int'(dut_b.fifo_count) > max_b) max_b = int'(dut_b.fifo_count);
    if (!rst_n) begin
      stall_a = 1'b0;
      stall_b = 1'b0;
    end else begin
      if (done_a) done_cnt_a++;
      if (done_b) done_cnt_b++;
      if (err_a)  err_cnt_a++;
      if (err_b)  err_cnt_b++;
      if (stall_a)
        check("stable_a", {pix_a.pix_valid, pix_a.pix_data, pix_a.pix_sof, pix_a.pix_eol, pix_a.pix_eof}, held_a);
      if (stall_b)
        check("stable_b", {pix_b.pix_valid, pix_b.pix_data, pix_b.pix_sof, pix_b.pix_eol, pix_b.pix_eof}, held_b);
      if (pix_a.pix_valid && ready) begin
        e = (exp_a.size() != 0) ? 32'(exp_a.pop_front()) : 32'hDEAD;
        check("pix_a", {pix_a.pix_data, pix_a.pix_sof, pix_a.pix_eol, pix_a.pix_eof}, e);
        acc_a++;
      end
      if (pix_b.pix_valid && ready) begin
        e = (exp_b.size() != 0) ? 32'(exp_b.pop_front()) : 32'hDEAD;
        check("pix_b", {pix_b.pix_data, pix_b.pix_sof, pix_b.pix_eol, pix_b.pix_eof}, e);
        acc_b++;
      end
      stall_a = pix_a.pix_valid && !ready;
      stall_b = pix_b.pix_valid && !ready;
      held_a  = {pix_a.pix_valid, pix_a.pix_data, pix_a.pix_sof, pix_a.pix_eol, pix_a.pix_eof};
      held_b  = {pix_b.pix_valid, pix_b.pix_data, pix_b.pix_sof, pix_b.pix_eol, pix_b.pix_eof};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (toggle_mode) begin
      ready = (phase == 0 || phase == 3);
      phase = (phase + 1) % 4;
    end
  endtask

  task automatic push_roi(input int x0, input int y0, input int w, input int h);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        int a;
        logic [10:0] e;
        a = (y0 + r) * 180 + x0 + c;
        e = {a[7:0], (r == 0 && c == 0), (c == w - 1), (r == h - 1 && c == w - 1)};
        exp_a.push_back(e);
        exp_b.push_back(e);
      end
    end
  endtask

  // Returns 1 ns after the edge that samples start.
  task automatic kick(input int x0, input int y0, input int w, input int h);
    tick();
    roi_x0 = 8'(x0);
    roi_y0 = 8'(y0);
    roi_w  = 8'(w);
    roi_h  = 8'(h);
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  task automatic wait_done(input int ta, input int tb_, input int budget, input string nm);
    int n;
    n = 0;
    while ((done_cnt_a < ta || done_cnt_b < tb_) && n < budget) begin
      tick();
      n++;
    end
    check({nm, "_done_seen"}, 32'(done_cnt_a >= ta && done_cnt_b >= tb_), 32'd1);
    repeat (3) tick();
    check({nm, "_done_once"}, {16'(done_cnt_a), 16'(done_cnt_b)}, {16'(ta), 16'(tb_)});
    check({nm, "_queue_a_empty"}, 32'(exp_a.size()), 32'd0);
    check({nm, "_queue_b_empty"}, 32'(exp_b.size()), 32'd0);
    check({nm, "_busy_low"}, {busy_a, busy_b}, 2'b00);
  endtask

  task automatic do_reject(input int x0, input int y0, input int w, input int h, input string nm);
    logic [16:0] sa, sb;
    int ea, eb;
    logic seen;
    sa = addr_a;
    sb = addr_b;
    ea = err_cnt_a;
    eb = err_cnt_b;
    kick(x0, y0, w, h);
    check({nm, "_err_pulse"}, {err_a, err_b}, 2'b11);
    check({nm, "_busy"}, {busy_a, busy_b}, 2'b00);
    seen = 1'b0;
    repeat (6) begin
      tick();
      seen = seen | pix_a.pix_valid | pix_b.pix_valid | busy_a | busy_b;
    end
    check({nm, "_no_activity"}, seen, 1'b0);
    check({nm, "_err_once"}, {16'(err_cnt_a - ea), 16'(err_cnt_b - eb)}, {16'd1, 16'd1});
    check({nm, "_addr_a_hold"}, addr_a, sa);
    check({nm, "_addr_b_hold"}, addr_b, sb);
  endtask

  initial begin
    int lat_a, lat_b, n, acc0, dca, dcb;
    rst_n  = 1'b0;
    start  = 1'b0;
    ready  = 1'b1;
    roi_x0 = '0;
    roi_y0 = '0;
    roi_w  = '0;
    roi_h  = '0;
    repeat (3) tick();
    check("rst_valid", {pix_a.pix_valid, pix_b.pix_valid}, 2'b00);
    check("rst_status", {busy_a, done_a, err_a, busy_b, done_b, err_b}, 6'b0);
    check("rst_addr_a", addr_a, 17'd0);
    check("rst_addr_b", addr_b, 17'd0);
    check("rst_data", {pix_a.pix_data, pix_b.pix_data}, 16'h0);
    rst_n = 1'b1;
    tick();

    // ROI (10,20,4,3) with first-valid latency measurement.
    push_roi(10, 20, 4, 3);
    kick(10, 20, 4, 3);
    lat_a = -1;
    lat_b = -1;
    for (int k = 0; k < 12; k++) begin
      if (lat_a < 0 && pix_a.pix_valid) lat_a = k;
      if (lat_b < 0 && pix_b.pix_valid) lat_b = k;
      if (k == 4) check("roi_busy_mid", {busy_a, busy_b}, 2'b11);
      tick();
    end
    check("first_valid_lat_a", 32'(lat_a), 32'(LAT_A + 2));
    check("first_valid_lat_b", 32'(lat_b), 32'(LAT_B + 2));
    wait_done(1, 1, 100, "roi4x3");

    do_reject(178, 0, 3, 1, "rej_xover");
    do_reject(0, 0, 0, 5, "rej_w0");

    // 1x1 ROI at (5,5): RAM[905] with all markers.
    push_roi(5, 5, 1, 1);
    kick(5, 5, 1, 1);
    wait_done(2, 2, 50, "roi1x1");

    // Backpressure 1,0,0,1 repeating.
    push_roi(0, 0, 16, 1);
    phase = 0;
    toggle_mode = 1'b1;
    kick(0, 0, 16, 1);
    wait_done(3, 3, 200, "stall16");
    toggle_mode = 1'b0;
    ready = 1'b1;

    // Full frame.
    push_roi(0, 0, 180, 150);
    kick(0, 0, 180, 150);
    wait_done(4, 4, 30000, "full");

    // Reset in the middle of a full-frame pass.
    acc0 = acc_a;
    push_roi(0, 0, 180, 150);
    kick(0, 0, 180, 150);
    n = 0;
    while (acc_a < acc0 + 500 && n < 2000) begin
      tick();
      n++;
    end
    check("rst_mid_reached", 32'(acc_a >= acc0 + 500), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", {pix_a.pix_valid, pix_b.pix_valid, busy_a, busy_b, pix_a.pix_sof, pix_a.pix_eol, pix_a.pix_eof}, 7'b0);
    check("rst_mid_addr_a", addr_a, 17'd0);
    check("rst_mid_addr_b", addr_b, 17'd0);
    exp_a.delete();
    exp_b.delete();
    dca = done_cnt_a;
    dcb = done_cnt_b;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    push_roi(0, 0, 2, 1);
    kick(0, 0, 2, 1);
    wait_done(dca + 1, dcb + 1, 50, "after_rst");

    check("wen_never", wen_seen, 1'b0);
    check("fifo_max_a", 32'(max_a <= LAT_A + 2), 32'd1);
    check("fifo_max_b", 32'(max_b <= LAT_B + 2), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
